// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
// Optional even-parity frames are selected by UART_RX_PARITY_EN.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  localparam int unsigned R_DATA = 32'h0;
  localparam int unsigned R_STAT = 32'h4;
  localparam int unsigned R_CTRL = 32'h8;
  localparam int unsigned R_DIV  = 32'hC;

  localparam int unsigned STAT_VALID   = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVERRUN = 2;
  localparam int unsigned STAT_FERR    = 3;
  localparam int unsigned STAT_PERR    = 4;
  localparam int unsigned STAT_BUSY    = 5;

  localparam logic [15:0] DIV_RST = 16'd868;
  localparam logic [15:0] DIV_MIN = 16'd4;

  localparam int unsigned FIFO_DEPTH = 4;

  function automatic logic [15:0] eff_period(
    input logic [15:0] div
  );
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Four-entry byte FIFO for received characters.
// A push into a full FIFO succeeds only when a pop lands in the same cycle.
module uart_rx_fifo
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       empty,
  output logic       full,
  output logic [7:0] head
);

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [1:0] wr_q, wr_d;
  logic [1:0] rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       do_push;
  logic       do_pop;

  assign empty   = (cnt_q == 3'd0);
  assign full    = (cnt_q == 3'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 2'd1;
    end
    if (do_pop) begin
      rd_d = rd_q + 2'd1;
    end
    cnt_d = cnt_q + {2'b00, do_push}
                  - {2'b00, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with local-bus registers and a 4-byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx_in,
  output logic              irq,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic [STRB_W-1:0] wstrb,
  output logic              wready,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic sync1_q, sync2_q, rx_s;

  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic [15:0] div_q, div_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;
  logic        ren_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic        rvalid_q;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [15:0] per_q;
  logic        push_q;
  logic        ferr_set_q;

  logic        empty, full;
  logic [7:0]  head;
  logic        perr_bit;
  logic [15:0] half;
  logic        bit_end;
  logic        wr_ctrl, wr_div;
  logic        rd_first, pop, clr;
  logic        ovr_set;
  logic [7:0]  stat;
  logic [DATA_W-1:0] rd_val;
  logic        unused_bus;

`ifdef UART_RX_PARITY_EN
  localparam state_t S_AFTER_DATA = S_PARITY;
  logic perr_q, perr_d, perr_set_q;
  assign perr_bit = perr_q;
`else
  localparam state_t S_AFTER_DATA = S_STOP;
  assign perr_bit = 1'b0;
`endif

  assign rx_s    = sync2_q;
  assign half    = per_q >> 1;
  assign bit_end = (cnt_q == per_q - 16'd1);

  assign wr_ctrl = wen && wstrb[0]
                && (waddr == ADDR_W'(R_CTRL));
  assign wr_div  = wen
                && (waddr == ADDR_W'(R_DIV));

  assign rd_first = ren && !ren_q;
  assign pop = rd_first
            && (raddr == ADDR_W'(R_DATA));
  assign clr = rd_first
            && (raddr == ADDR_W'(R_STAT));

  assign ovr_set = push_q && full && !pop;

  assign stat = {2'b00,
                 state_q != S_IDLE,
                 perr_bit,
                 ferr_q,
                 ovr_q,
                 full,
                 !empty};

  assign unused_bus = ^{wdata[DATA_W-1:16],
                        wstrb[STRB_W-1:2]};

  uart_rx_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (pop),
    .din   (shift_q),
    .empty (empty),
    .full  (full),
    .head  (head)
  );

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      raddr == ADDR_W'(R_DATA): rd_val[7:0]  = head;
      raddr == ADDR_W'(R_STAT): rd_val[7:0]  = stat;
      raddr == ADDR_W'(R_CTRL): rd_val[1:0]  = {ie_q, en_q};
      raddr == ADDR_W'(R_DIV):  rd_val[15:0] = div_q;
      default: ;
    endcase
  end

  always_comb begin
    en_d  = en_q;
    ie_d  = ie_q;
    div_d = div_q;
    if (wr_ctrl) begin
      en_d = wdata[0];
      ie_d = wdata[1];
    end
    if (wr_div && wstrb[0]) div_d[7:0]  = wdata[7:0];
    if (wr_div && wstrb[1]) div_d[15:8] = wdata[15:8];
    // a set in the same cycle as a status-read clear wins
    ovr_d   = ovr_set | (ovr_q & !clr);
    ferr_d  = ferr_set_q | (ferr_q & !clr);
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_set_q | (perr_q & !clr);
`endif
    rdata_d = ren ? rd_val : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      div_q    <= DIV_RST;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q   <= 1'b0;
`endif
      ren_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      sync1_q  <= uart_rx_in;
      sync2_q  <= sync1_q;
      en_q     <= en_d;
      ie_q     <= ie_d;
      div_q    <= div_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q   <= perr_d;
`endif
      ren_q    <= ren;
      rdata_q  <= rdata_d;
      rvalid_q <= ren;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      per_q      <= DIV_RST;
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_set_q <= 1'b0;
`endif
    end else begin
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_set_q <= 1'b0;
`endif
      // divider changes only apply between frames
      if (state_q == S_IDLE) per_q <= eff_period(div_q);
      if (!en_q) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        idx_q   <= '0;
        shift_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!rx_s) begin
              state_q <= S_START;
              cnt_q   <= '0;
            end
          end
          S_START: begin
            if (cnt_q == half - 16'd1) begin
              cnt_q   <= '0;
              idx_q   <= '0;
              state_q <= rx_s ? S_IDLE : S_DATA;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          S_DATA: begin
            if (bit_end) begin
              cnt_q   <= '0;
              shift_q <= {rx_s, shift_q[7:1]};
              idx_q   <= idx_q + 3'd1;
              if (idx_q == 3'd7) state_q <= S_AFTER_DATA;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (bit_end) begin
              cnt_q      <= '0;
              perr_set_q <= ^{shift_q, rx_s};
              state_q    <= S_STOP;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
`endif
          S_STOP: begin
            if (bit_end) begin
              cnt_q  <= '0;
              push_q <= 1'b1;
              if (!rx_s) begin
                ferr_set_q <= 1'b1;
                state_q    <= S_WAIT_HIGH;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          S_WAIT_HIGH: begin
            if (rx_s) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign irq    = ie_q && !empty;
  assign wready = 1'b1;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: register table plus
// serial-frame scenarios checked against a FIFO scoreboard.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_in = 1'b1;
  logic        irq;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic        wen = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        wready;
  logic [31:0] raddr = '0;
  logic        ren = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;

  int tests = 0;
  int fails = 0;
  int per = 16;
  logic [7:0] sb[$];
  bit m_ovr = 1'b0;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vt[$];

  always #5 clk = ~clk;

  uart_rx dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx_in (uart_in),
    .irq        (irq),
    .waddr      (waddr),
    .wdata      (wdata),
    .wen        (wen),
    .wstrb      (wstrb),
    .wready     (wready),
    .raddr      (raddr),
    .ren        (ren),
    .rdata      (rdata),
    .rvalid     (rvalid)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s);
    @(negedge clk);
    waddr = a;
    wdata = d;
    wstrb = s;
    wen   = 1'b1;
    @(negedge clk);
    wen   = 1'b0;
    wstrb = '0;
  endtask

  task automatic bus_read(input string name,
                          input logic [31:0] a,
                          input int len,
                          input logic [31:0] exp0,
                          input logic [31:0] expn);
    @(negedge clk);
    raddr = a;
    ren   = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check({name, "/rvalid"}, {31'b0, rvalid}, 32'd1);
      check(name, rdata, (i == 0) ? exp0 : expn);
    end
    ren = 1'b0;
    @(negedge clk);
    check({name, "/rvalid_lo"}, {31'b0, rvalid}, 32'd0);
    check({name, "/rdata_lo"}, rdata, 32'd0);
  endtask

  function automatic logic [31:0] stat_model(
    input bit busy, input bit ferr, input bit perr);
    return {26'b0, busy, perr, ferr, m_ovr,
            sb.size() == 4, sb.size() != 0};
  endfunction

  task automatic read_stat(input string name,
                           input bit busy,
                           input bit ferr,
                           input bit perr);
    logic [31:0] e;
    e = stat_model(busy, ferr, perr);
    bus_read(name, 32'h4, 1, e, e);
    m_ovr = 1'b0;
  endtask

  task automatic read_data(input string name);
    logic [7:0] e;
    e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    bus_read(name, 32'h0, 1, {24'b0, e}, {24'b0, e});
  endtask

  task automatic drive_line(input logic v, input int n);
    uart_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic model_push(input logic [7:0] b);
    if (sb.size() < 4) sb.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b,
                           input bit bad_par);
    drive_line(1'b0, per);
    for (int i = 0; i < 8; i++) drive_line(b[i], per);
    if (PAR) drive_line(^b ^ bad_par, per);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit bad_par);
    send_bits(b, bad_par);
    drive_line(1'b1, per);
    model_push(b);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] e0;
    logic [7:0] e1;
    int n;

    repeat (3) @(negedge clk);
    check("rst/irq", {31'b0, irq}, 32'd0);
    check("rst/wready", {31'b0, wready}, 32'd1);
    check("rst/rvalid", {31'b0, rvalid}, 32'd0);
    check("rst/rdata", rdata, 32'd0);
    rst = 1'b0;

    vt.push_back('{1'b0, 32'h0, 32'h0, 4'h0, 32'h0, "r_data"});
    vt.push_back('{1'b0, 32'h4, 32'h0, 4'h0, 32'h0, "r_stat"});
    vt.push_back('{1'b0, 32'h8, 32'h0, 4'h0, 32'h0, "r_ctrl"});
    vt.push_back('{1'b0, 32'hC, 32'h0, 4'h0, 32'd868, "r_div"});
    vt.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 32'h0, "r_unmap"});
    vt.push_back('{1'b1, 32'hC, 32'h1234, 4'h1, 32'h0, ""});
    vt.push_back('{1'b0, 32'hC, 32'h0, 4'h0, 32'h334, "div_lo"});
    vt.push_back('{1'b1, 32'hC, 32'h0, 4'h2, 32'h0, ""});
    vt.push_back('{1'b0, 32'hC, 32'h0, 4'h0, 32'h34, "div_hi"});
    vt.push_back('{1'b1, 32'hC, 32'h10, 4'h3, 32'h0, ""});
    vt.push_back('{1'b0, 32'hC, 32'h0, 4'h0, 32'h10, "div_16"});
    vt.push_back('{1'b1, 32'h8, 32'h3, 4'h0, 32'h0, ""});
    vt.push_back('{1'b0, 32'h8, 32'h0, 4'h0, 32'h0, "ctrl_nostrb"});
    vt.push_back('{1'b1, 32'h10, 32'hFF, 4'hF, 32'h0, ""});
    vt.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 32'h0, "unmap_wr"});
    vt.push_back('{1'b1, 32'h8, 32'h1, 4'h1, 32'h0, ""});
    vt.push_back('{1'b0, 32'h8, 32'h0, 4'h0, 32'h1, "ctrl_en"});

    foreach (vt[i]) begin
      if (vt[i].wr)
        bus_write(vt[i].a, vt[i].d, vt[i].s);
      else
        bus_read(vt[i].name, vt[i].a, 1,
                 vt[i].exp, vt[i].exp);
    end
    drive_line(1'b1, 4);

    // single byte
    send_frame(8'h55, 1'b0);
    read_stat("b55/stat", 1'b0, 1'b0, 1'b0);
    read_data("b55/data");
    read_stat("b55/stat2", 1'b0, 1'b0, 1'b0);

    // overrun: five frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0);
    read_stat("ovr/stat", 1'b0, 1'b0, 1'b0);
    e0 = sb.pop_front();
    e1 = sb[0];
    bus_read("ovr/burst", 32'h0, 3,
             {24'b0, e0}, {24'b0, e1});
    for (int i = 0; i < 3; i++) read_data("ovr/data");
    read_stat("ovr/stat2", 1'b0, 1'b0, 1'b0);

    // framing error with stop bit held low
    send_bits(8'hA3, 1'b0);
    drive_line(1'b0, 2 * per);
    model_push(8'hA3);
    read_stat("ferr/stat", 1'b1, 1'b1, 1'b0);
    drive_line(1'b0, per);
    drive_line(1'b1, 8);
    read_stat("ferr/clr", 1'b0, 1'b0, 1'b0);
    read_data("ferr/data");
    read_stat("ferr/stat2", 1'b0, 1'b0, 1'b0);

    // start-bit glitch
    drive_line(1'b0, 4);
    drive_line(1'b1, 3 * per);
    read_stat("glitch/stat", 1'b0, 1'b0, 1'b0);

    // interrupt
    bus_write(32'h8, 32'h3, 4'h1);
    check("irq/idle", {31'b0, irq}, 32'd0);
    send_bits(8'h7E, 1'b0);
    uart_in = 1'b1;
    model_push(8'h7E);
    n = 0;
    while (!irq && n < 4 * per) begin
      @(negedge clk);
      n++;
    end
    check("irq/rise", {31'b0, irq}, 32'd1);
    drive_line(1'b1, per);
    read_data("irq/data");
    check("irq/fall", {31'b0, irq}, 32'd0);
    bus_write(32'h8, 32'h1, 4'h1);

    // EN=0 aborts a partial frame
    drive_line(1'b0, per);
    drive_line(1'b1, per);
    drive_line(1'b0, per);
    bus_write(32'h8, 32'h0, 4'h1);
    uart_in = 1'b1;
    read_stat("abort/stat", 1'b0, 1'b0, 1'b0);
    bus_write(32'h8, 32'h1, 4'h1);
    drive_line(1'b1, 2 * per);
    send_frame(8'h3C, 1'b0);
    read_data("abort/next");

    // reset in the middle of a frame
    drive_line(1'b0, per);
    for (int i = 0; i < 3; i++) drive_line(1'b1, per);
    rst = 1'b1;
    @(negedge clk);
    check("mrst/rdata", rdata, 32'd0);
    check("mrst/rvalid", {31'b0, rvalid}, 32'd0);
    check("mrst/irq", {31'b0, irq}, 32'd0);
    rst = 1'b0;
    uart_in = 1'b1;
    sb.delete();
    m_ovr = 1'b0;
    drive_line(1'b1, 2 * per);
    read_data("mrst/data");
    read_stat("mrst/stat", 1'b0, 1'b0, 1'b0);
    bus_read("mrst/ctrl", 32'h8, 1, 32'h0, 32'h0);
    bus_read("mrst/div", 32'hC, 1, 32'd868, 32'd868);

    // odd-parity frame (parity error only in the parity build)
    bus_write(32'hC, 32'h10, 4'h3);
    bus_write(32'h8, 32'h1, 4'h1);
    drive_line(1'b1, 4);
    send_frame(8'h01, 1'b1);
    read_stat("par/stat", 1'b0, 1'b0, PAR);
    read_data("par/data");
    read_stat("par/stat2", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
